fetch_stage: RTL and testbench

- Instruction fetch stage that sits directly upstream of the decode-stage control unit.
- Owns the PC and issues in-order requests to instruction memory.
- Buffers returned instructions in a small prefetch FIFO and presents them to decode with a valid/ready handshake.
- Decode slices id_instr into opcode, funct3 and funct7 for the control decoder. Execute redirects fetch on taken branches and jumps.

---
 rtl/fetch_stage.sv | 95 +++++++++
 tb/tb_fetch_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues in-order imem requests on a credit basis and
// buffers returned instructions in a prefetch FIFO feeding decode.
module fetch_stage #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            id_ready,
   output logic            id_valid,
   output logic [XLEN-1:0] id_instr,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc_plus4
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] CAP = (CW+1)'(DEPTH);
   localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

   logic [XLEN-1:0] pc_q, pc_d, last_pc_q;
   logic [CW-1:0]   cnt_q, cnt_d, out_q, out_d, disc_q, disc_d;
   logic [AW-1:0]   wr_q, rd_q, pq_wr_q, pq_rd_q;
   logic            started_q;
   logic [XLEN-1:0] instr_mem_q [DEPTH];
   logic [XLEN-1:0] pc_mem_q [DEPTH];
   logic [XLEN-1:0] pq_mem_q [DEPTH];
   logic            req_fire, push, pop;
   logic [CW:0]     credit;

   // Buffered plus in-flight never exceeds DEPTH, so every response has a slot.
   assign credit         = {1'b0, cnt_q} + {1'b0, out_q};
   assign imem_req_valid = started_q && !redirect_valid && credit < CAP;
   assign imem_req_addr  = {pc_q[XLEN-1:2], 2'b00};
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign push           = imem_rsp_valid && !redirect_valid && disc_q == '0;
   assign pop            = id_valid && id_ready && !redirect_valid;
   assign id_valid       = cnt_q != '0;
   assign id_instr       = id_valid ? instr_mem_q[rd_q] : NOP;
   assign id_pc          = id_valid ? pc_mem_q[rd_q] : last_pc_q;
   assign id_pc_plus4    = id_pc + XLEN'(4);

   always_comb begin
      pc_d   = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} : req_fire ? pc_q + XLEN'(4) : pc_q;
      out_d  = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
      cnt_d  = redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
      disc_d = redirect_valid ? out_q - CW'(imem_rsp_valid) : disc_q - CW'(imem_rsp_valid && disc_q != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q      <= {RESET_PC[XLEN-1:2], 2'b00};
         cnt_q     <= '0;
         out_q     <= '0;
         disc_q    <= '0;
         wr_q      <= '0;
         rd_q      <= '0;
         pq_wr_q   <= '0;
         pq_rd_q   <= '0;
         started_q <= 1'b0;
         last_pc_q <= '0;
      end else begin
         pc_q      <= pc_d;
         cnt_q     <= cnt_d;
         out_q     <= out_d;
         disc_q    <= disc_d;
         wr_q      <= redirect_valid ? '0 : wr_q + AW'(push);
         rd_q      <= redirect_valid ? '0 : rd_q + AW'(pop);
         pq_wr_q   <= pq_wr_q + AW'(req_fire);
         pq_rd_q   <= pq_rd_q + AW'(imem_rsp_valid);
         started_q <= 1'b1;
         last_pc_q <= id_valid ? id_pc : last_pc_q;
      end
   end

   // Request PC queue is popped by every response, including discarded ones.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[wr_q] <= imem_rsp_data;
         pc_mem_q[wr_q]    <= pq_mem_q[pq_rd_q];
      end
      if (req_fire) pq_mem_q[pq_wr_q] <= imem_req_addr;
   end

   a_no_rsp_underflow: assert property (@(posedge clk) disable iff (rst) imem_rsp_valid |-> out_q != '0);
   a_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !pop && cnt_q == CW'(DEPTH)));
   a_no_out_overflow:  assert property (@(posedge clk) disable iff (rst) !(req_fire && !imem_rsp_valid && out_q == CW'(DEPTH)));
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: in-order memory model plus an expected-instruction-stream scoreboard
// (every request accepted since the last flush is delivered once, in order).
module tb_fetch_stage;
   localparam int DEPTH = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0, rst = 1'b1;
   logic imem_req_valid, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
   logic [31:0] imem_req_addr, imem_rsp_data = '0, redirect_pc = '0;
   logic redirect_valid = 1'b0, id_ready = 1'b0, id_valid;
   logic [31:0] id_instr, id_pc, id_pc_plus4;

   fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
   mreq_t mem_q[$];
   logic [31:0] exp_q[$];
   int epoch = 0, cyc = 0, last_due = 0, lat_lo = 1, lat_hi = 1, n_chk = 0, n_pass = 0;
   logic [31:0] m_pc = '0, last_pc = '0;
   bit started = 1'b0, rsp_now;
   bit e_req, e_valid;
   logic [31:0] e_addr, e_instr, e_pc;

   function automatic int live_pending();
      int n = 0;
      foreach (mem_q[i]) if (mem_q[i].epoch == epoch) n++;
      return n;
   endfunction

   task automatic step(input bit rdy, input bit mrdy, input bit redir, input logic [31:0] tgt);
      int buffered, d;
      @(posedge clk);
      cyc++;
      if (!rst) started = 1'b1;
      #1;
      rsp_now = 1'b0;
      if (mem_q.size() > 0) rsp_now = mem_q[0].due <= cyc;
      imem_rsp_valid = rsp_now;
      imem_rsp_data  = $urandom;
      if (rsp_now) imem_rsp_data = mem_q[0].addr >> 2;
      id_ready = rdy; imem_req_ready = mrdy; redirect_valid = redir; redirect_pc = tgt;
      buffered = exp_q.size() - live_pending();
      e_valid  = buffered > 0;
      e_req    = started && !redir && (buffered + mem_q.size() < DEPTH);
      e_addr   = m_pc;
      e_pc     = e_valid ? exp_q[0] : last_pc;
      e_instr  = e_valid ? exp_q[0] >> 2 : NOP;
      @(negedge clk);
      if (rsp_now) void'(mem_q.pop_front());
      if (imem_req_valid && imem_req_ready) begin
         d = cyc + $urandom_range(lat_hi, lat_lo);
         if (d <= last_due) d = last_due + 1;
         last_due = d;
         mem_q.push_back('{imem_req_addr, epoch, d});
      end
      if (e_valid) last_pc = e_pc;
      if (redir) begin
         exp_q.delete(); epoch++; m_pc = {tgt[31:2], 2'b00};
      end else begin
         if (e_valid && rdy) void'(exp_q.pop_front());
         if (e_req && mrdy) begin exp_q.push_back(m_pc); m_pc += 32'd4; end
      end
   endtask

   task automatic test_reset();
      #2;
      n_chk++;
      if ({imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4} !== {1'b0, 32'd0, 1'b0, NOP, 32'd0, 32'd4})
         $display("FAIL reset_values got req=%b a=%h v=%b i=%h pc=%h p4=%h", imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4);
      else n_pass++;
      step(1, 1, 0, 0);
      n_chk++;
      if ({imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4} !== {e_req, e_addr, e_valid, e_instr, e_pc, e_pc + 32'd4})
         $display("FAIL reset_hold cyc=%0d got req=%b v=%b i=%h pc=%h exp req=%b v=%b i=%h pc=%h", cyc, imem_req_valid, id_valid, id_instr, id_pc, e_req, e_valid, e_instr, e_pc);
      else n_pass++;
      #1 rst = 1'b0;
      #1;
      n_chk++;
      if (imem_req_valid !== 1'b0) $display("FAIL reset_release_req got %b exp 0", imem_req_valid);
      else n_pass++;
   endtask

   task automatic test_stream();
      int nv = 0;
      lat_lo = 1; lat_hi = 1;
      repeat (20) begin
         step(1, 1, 0, 0);
         nv += int'(id_valid);
         n_chk++;
         if ({imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4} !== {e_req, e_addr, e_valid, e_instr, e_pc, e_pc + 32'd4})
            $display("FAIL stream cyc=%0d got req=%b a=%h v=%b i=%h pc=%h p4=%h exp req=%b a=%h v=%b i=%h pc=%h", cyc, imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4, e_req, e_addr, e_valid, e_instr, e_pc);
         else n_pass++;
      end
      n_chk++;
      if (nv != 18) $display("FAIL throughput got %0d valid cycles exp 18", nv);
      else n_pass++;
   endtask

   task automatic test_stall();
      logic [64:0] frozen;
      repeat (3) step(1, 1, 0, 0);
      for (int i = 0; i < 15; i++) begin
         step(i >= 5, 1, 0, 0);
         if (i == 0) frozen = {id_valid, id_instr, id_pc};
         n_chk++;
         if ({imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4} !== {e_req, e_addr, e_valid, e_instr, e_pc, e_pc + 32'd4})
            $display("FAIL stall_stream cyc=%0d got req=%b a=%h v=%b i=%h pc=%h exp req=%b a=%h v=%b i=%h pc=%h", cyc, imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, e_req, e_addr, e_valid, e_instr, e_pc);
         else n_pass++;
         if (i > 0 && i < 5) begin
            n_chk++;
            if ({id_valid, id_instr, id_pc} !== frozen || frozen[64] !== 1'b1)
               $display("FAIL stall_frozen cyc=%0d got %h exp %h", cyc, {id_valid, id_instr, id_pc}, frozen);
            else n_pass++;
         end
      end
   endtask

   task automatic test_req_stall();
      logic [31:0] held;
      for (int i = 0; i < 5; i++) begin
         step(1, i >= 3, 0, 0);
         if (i == 0) held = imem_req_addr;
         n_chk++;
         if (imem_req_addr !== (i < 4 ? held : held + 32'd4) || imem_req_addr !== e_addr)
            $display("FAIL req_stall_addr cyc=%0d got %h exp %h", cyc, imem_req_addr, i < 4 ? held : held + 32'd4);
         else n_pass++;
      end
   endtask

   task automatic test_redirect();
      bit found = 1'b0;
      lat_lo = 3; lat_hi = 3;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1, 1, 0, 0);
         found = live_pending() >= 2;
      end
      n_chk++;
      if (!found) $display("FAIL redirect_setup in_flight got %0d exp >=2", live_pending());
      else n_pass++;
      step(1, 1, 1, 32'h0000_0100);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1, 1, 0, 0);
         found = id_valid;
         n_chk++;
         if ({imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4} !== {e_req, e_addr, e_valid, e_instr, e_pc, e_pc + 32'd4})
            $display("FAIL redirect_stream cyc=%0d got req=%b a=%h v=%b i=%h pc=%h exp req=%b a=%h v=%b i=%h pc=%h", cyc, imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, e_req, e_addr, e_valid, e_instr, e_pc);
         else n_pass++;
      end
      n_chk++;
      if (!found || id_pc !== 32'h100 || id_instr !== 32'h40)
         $display("FAIL redirect_target got v=%b pc=%h i=%h exp v=1 pc=00000100 i=00000040", id_valid, id_pc, id_instr);
      else n_pass++;
      lat_lo = 1; lat_hi = 1;
   endtask

   task automatic test_redirect_rsp();
      bit found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step(1, 1, 0, 0);
         if (mem_q.size() > 0) found = mem_q[0].due == cyc + 1;
      end
      n_chk++;
      if (!found) $display("FAIL redirect_rsp_setup got no pending response exp one");
      else n_pass++;
      step(1, 1, 1, 32'h0000_0200);
      step(1, 1, 0, 0);
      n_chk++;
      if (id_valid !== 1'b0 || id_instr !== NOP) $display("FAIL redirect_rsp_flush got v=%b i=%h exp v=0 i=%h", id_valid, id_instr, NOP);
      else n_pass++;
   endtask

   task automatic test_wrap();
      bit saw0 = 1'b0;
      step(1, 1, 1, 32'hFFFF_FFFA);
      for (int i = 0; i < 12; i++) begin
         step(1, 1, 0, 0);
         if (imem_req_valid && imem_req_ready && imem_req_addr == 32'h0) saw0 = 1'b1;
         n_chk++;
         if ({imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4} !== {e_req, e_addr, e_valid, e_instr, e_pc, e_pc + 32'd4})
            $display("FAIL wrap_stream cyc=%0d got req=%b a=%h v=%b i=%h pc=%h p4=%h exp req=%b a=%h v=%b i=%h pc=%h", cyc, imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4, e_req, e_addr, e_valid, e_instr, e_pc);
         else n_pass++;
      end
      n_chk++;
      if (!saw0) $display("FAIL wrap_addr got no request at 00000000 exp one");
      else n_pass++;
   endtask

   task automatic test_async_reset();
      lat_lo = 2; lat_hi = 2;
      repeat (6) step(1, 1, 0, 0);
      #2 rst = 1'b1; imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
      #1;
      n_chk++;
      if ({imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4} !== {1'b0, 32'd0, 1'b0, NOP, 32'd0, 32'd4})
         $display("FAIL async_reset_values got req=%b a=%h v=%b i=%h pc=%h p4=%h", imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4);
      else n_pass++;
      mem_q.delete(); exp_q.delete(); epoch++;
      m_pc = '0; last_pc = '0; started = 1'b0; last_due = cyc;
      step(1, 1, 0, 0);
      #1 rst = 1'b0;
      #1;
      n_chk++;
      if (imem_req_valid !== 1'b0) $display("FAIL async_release_req got %b exp 0", imem_req_valid);
      else n_pass++;
      repeat (12) begin
         step(1, 1, 0, 0);
         n_chk++;
         if ({imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4} !== {e_req, e_addr, e_valid, e_instr, e_pc, e_pc + 32'd4})
            $display("FAIL async_resume cyc=%0d got req=%b a=%h v=%b i=%h pc=%h exp req=%b a=%h v=%b i=%h pc=%h", cyc, imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, e_req, e_addr, e_valid, e_instr, e_pc);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      lat_lo = 1; lat_hi = 3;
      repeat (800) begin
         step($urandom_range(99) < 70, $urandom_range(99) < 70, $urandom_range(99) < 3, $urandom);
         n_chk++;
         if ({imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4} !== {e_req, e_addr, e_valid, e_instr, e_pc, e_pc + 32'd4})
            $display("FAIL random cyc=%0d got req=%b a=%h v=%b i=%h pc=%h p4=%h exp req=%b a=%h v=%b i=%h pc=%h", cyc, imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus4, e_req, e_addr, e_valid, e_instr, e_pc);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_req_stall();
      test_redirect();
      test_redirect_rsp();
      test_wrap();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cyc=%0d", cyc);
      $fatal(1, "timeout");
   end
endmodule
